truth_table_sweeper: RTL and testbench

- Sequencer that drives all 16 input rows into one 4-input combinational logic circuit (in1..in4 -> out) and waits a programmable settle time per row.
- Samples the circuit output through a 2-flop synchronizer and assembles the measured 16-bit truth table.
- Compares the measured table with an expected table and reports mismatches.
- Sits between a test/configuration host and one gate-level design under characterization.

---
 rtl/truth_table_sweeper_if.sv | 32 +++
 rtl/truth_table_sweeper.sv | 135 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Host/circuit bundle for the truth-table sweeper: sweep control, results and
// the four row drives plus the measured output of the circuit under test.
interface truth_table_sweeper_if #(
    parameter int SETTLE_W = 8
);
    logic                start;
    logic                abort;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                dut_in1;
    logic                dut_in2;
    logic                dut_in3;
    logic                dut_in4;
    logic                dut_out;
    logic                busy;
    logic                done;
    logic [15:0]         captured;
    logic                mismatch;
    logic [4:0]          mismatch_count;
    logic [3:0]          first_fail_row;

    modport master (
        output start, abort, settle_cycles, dut_out,
        input  dut_in1, dut_in2, dut_in3, dut_in4,
        input  busy, done, captured, mismatch, mismatch_count, first_fail_row
    );

    modport slave (
        input  start, abort, settle_cycles, dut_out,
        output dut_in1, dut_in2, dut_in3, dut_in4,
        output busy, done, captured, mismatch, mismatch_count, first_fail_row
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 16 input rows of a 4-input circuit, samples its synchronized output
// after a programmable settle time and compares the table with EXPECTED.
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h9F8A,
    parameter int          SETTLE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sweeper_if.slave   bus
);
    localparam int CW = SETTLE_W + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state;
    logic [SETTLE_W-1:0] settle_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          row_q;
    logic                sync_p0;
    logic                sync_p1;
    logic                busy_q;
    logic                done_q;
    logic [15:0]         captured_q;
    logic                mismatch_q;
    logic [4:0]          count_q;
    logic [3:0]          ffr_q;

    logic [3:0]          cap_idx;
    logic [CW-1:0]       start_reload;
    logic [CW-1:0]       row_reload;

    // Row r lives at bit 15-r, which for a 4-bit index is its complement.
    assign cap_idx      = ~row_q;
    assign start_reload = CW'(bus.settle_cycles) + CW'(2);
    assign row_reload   = CW'(settle_q) + CW'(2);

    // Two-flop synchronizer for the asynchronous circuit output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.dut_out;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_q   <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            captured_q <= '0;
            mismatch_q <= 1'b0;
            count_q    <= '0;
            ffr_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        settle_q   <= bus.settle_cycles;
                        row_q      <= '0;
                        captured_q <= '0;
                        mismatch_q <= 1'b0;
                        count_q    <= '0;
                        ffr_q      <= '0;
                        cnt_q      <= start_reload;
                        busy_q     <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        row_q      <= '0;
                        busy_q     <= 1'b0;
                        mismatch_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        row_q      <= '0;
                        busy_q     <= 1'b0;
                        mismatch_q <= 1'b0;
                    end else begin
                        captured_q[cap_idx] <= sync_p1;
                        if (sync_p1 != EXPECTED[cap_idx]) begin
                            count_q <= count_q + 5'd1;
                            if (count_q == 5'd0) begin
                                ffr_q <= row_q;
                            end
                        end
                        if (row_q == 4'd15) begin
                            state  <= DONE;
                            row_q  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            row_q <= row_q + 4'd1;
                            cnt_q <= row_reload;
                            state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done_q     <= 1'b1;
                    mismatch_q <= (count_q != 5'd0);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in1        = row_q[3];
    assign bus.dut_in2        = row_q[2];
    assign bus.dut_in3        = row_q[1];
    assign bus.dut_in4        = row_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.captured       = captured_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.mismatch_count = count_q;
    assign bus.first_fail_row = ffr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a behavioural gate model (with
// optional faults) closes the loop; completed sweeps are checked on done.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.SETTLE_W(8)) bus ();

    truth_table_sweeper #(.EXPECTED(16'h9F8A), .SETTLE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] cap;
        logic        mm;
        logic [4:0]  cnt;
        logic [3:0]  ffr;
        int          done_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mode     = 0;  // 0 golden, 1 stuck-at-0, 2 row 9 flipped to 1
    logic [3:0] row;

    assign row = {bus.dut_in1, bus.dut_in2, bus.dut_in3, bus.dut_in4};

    function automatic logic model(input logic [3:0] r, input int m);
        logic in1, in2, in3, in4, g;
        in1 = r[3]; in2 = r[2]; in3 = r[1]; in4 = r[0];
        g = (~in4 & (~in3 | in2)) | (~in1 & ((in3 & in4) | in2));
        if (m == 1) return 1'b0;
        if (m == 2 && r == 4'd9) return 1'b1;
        return g;
    endfunction

    always_comb bus.dut_out = model(row, mode);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("captured", bus.captured, mon_e.cap);
                check("mismatch", bus.mismatch, mon_e.mm);
                check("mismatch_count", bus.mismatch_count, mon_e.cnt);
                check("first_fail_row", bus.first_fail_row, mon_e.ffr);
                check("done_busy_low", bus.busy, 1'b0);
                check("done_row_zero", row, 4'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int s, output int k);
        bus.settle_cycles = 8'(s);
        bus.start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic expect_sweep(input int k, input int s, input logic [15:0] cap,
                                input logic [4:0] cnt, input logic [3:0] ffr);
        exp_t e;
        e.cap = cap; e.cnt = cnt; e.ffr = ffr; e.mm = (cnt != 5'd0);
        e.done_cyc = k + 16 * (s + 3) + 1;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sbq.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  k;
        logic ok;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.settle_cycles = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_captured", bus.captured, 16'h0);
        check("rst_stats", {bus.mismatch, bus.mismatch_count, bus.first_fail_row}, 10'h0);
        check("rst_row", row, 4'd0);
        rst_n = 1'b1;
        tick(2);

        // Golden, S=0
        mode = 0;
        do_start(0, k);
        expect_sweep(k, 0, 16'h9F8A, 5'd0, 4'd0);
        check("busy_after_start", bus.busy, 1'b1);
        wait_drain();
        tick(3);
        check("hold_captured", bus.captured, 16'h9F8A);
        check("hold_mismatch", bus.mismatch, 1'b0);

        // Golden, S=5: each row held exactly 8 cycles
        do_start(5, k);
        expect_sweep(k, 5, 16'h9F8A, 5'd0, 4'd0);
        for (int r = 0; r < 16; r++) begin
            ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (row != 4'(r)) ok = 1'b0;
                tick(1);
            end
            check($sformatf("row_hold_%0d", r), ok, 1'b1);
        end
        check("row_after_sweep", row, 4'd0);
        wait_drain();

        // Stuck-at-0 output
        mode = 1;
        do_start(0, k);
        expect_sweep(k, 0, 16'h0000, 5'd9, 4'd0);
        wait_drain();

        // Row 9 flipped
        mode = 2;
        do_start(0, k);
        expect_sweep(k, 0, 16'h9FCA, 5'd1, 4'd9);
        wait_drain();

        // start re-asserted during row 4 is ignored
        mode = 0;
        do_start(0, k);
        expect_sweep(k, 0, 16'h9F8A, 5'd0, 4'd0);
        tick(13);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("restart_ignored_row", row, 4'd4);
        check("restart_ignored_busy", bus.busy, 1'b1);
        wait_drain();

        // abort during row 7 SETTLE
        do_start(0, k);
        tick(21);
        check("abort_pre_row", row, 4'd7);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_row", row, 4'd0);
        check("abort_mismatch", bus.mismatch, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_partial", bus.captured, 16'h9E00);
        tick(60);
        check("abort_stays_idle", bus.busy, 1'b0);

        // async reset during row 3 SAMPLE
        mode = 1;
        do_start(0, k);
        tick(11);
        check("pre_reset_count", bus.mismatch_count, 5'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_row", row, 4'd0);
        check("mid_rst_stats", {bus.mismatch, bus.mismatch_count, bus.first_fail_row}, 10'h0);
        check("mid_rst_captured", bus.captured, 16'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        mode = 0;
        do_start(0, k);
        expect_sweep(k, 0, 16'h9F8A, 5'd0, 4'd0);
        wait_drain();
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
